// File: rtl/uart_out_pkg.sv
// Shared definitions for the 8N1 output-port serializer: FSM encoding and defaults.
package uart_out_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 4;
    localparam int UART_DEFAULT_DEPTH        = 4;

    // LSB-first serialization: the next bit to send always sits in bit 0.
    function automatic logic [7:0] shift_lsb_out(input logic [7:0] d);
        return {1'b0, d[7:1]};
    endfunction

endpackage

// File: rtl/uart_out_fifo.sv
// Small synchronous FIFO with show-ahead head output; a push is accepted when
// full only if a pop happens on the same edge.
module uart_out_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic         full,
    output logic         empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign out       = mem_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= in;
    end

endmodule

// File: rtl/uart_out.sv
// Output-port serializer: queues OUT-strobe bytes and sends each one as an
// 8N1 frame on a registered tx line, back-to-back while data is queued.
module uart_out
    import uart_out_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = UART_DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       load,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic          pop_s;
    logic          baud_wrap_s;
    logic [7:0]    head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    uart_out_fifo #(
        .N     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (load),
        .pop   (pop_s),
        .in    (in),
        .out   (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign baud_wrap_s = (baud_q == BAUD_LAST);

    // Transmitter next-state; tx_d is the line value for the state being entered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    state_d = UART_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = UART_IDLE;
                end
            end
            UART_START: begin
                if (baud_wrap_s) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_wrap_s) begin
                    baud_d  = '0;
                    shift_d = shift_lsb_out(shift_q);
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_wrap_s) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        state_d = UART_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = UART_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A push is dropped only when the queue is full and nothing leaves this edge.
    always_comb begin
        overflow_d = overflow_q;
        if (load && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Transmitter and sticky-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != UART_IDLE);
    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_out.sv
// Directed bench for uart_out: a negedge line receiver decodes frames while one
// initial block drives OUT strobes and checks flags, data and frame timing.
module tb_uart_out;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       load;
    logic       tx, busy, full, empty, overflow;

    int errors = 0;
    int checks = 0;

    uart_out #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .load     (load),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Line receiver: samples every cycle, keeps 10*CPB samples per frame.
    int          cyc = 0;
    logic        rx_act = 1'b0;
    int          rx_k = 0;
    int          cur_start = 0;
    logic [39:0] smp;
    logic [7:0]  rx_data [$];
    int          rx_start [$];
    logic        rx_ok [$];

    always @(negedge clk) begin
        logic       ok;
        logic [7:0] d;
        cyc++;
        if (reset === 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act    = 1'b1;
                rx_k      = 0;
                cur_start = cyc;
                smp       = 40'h0;
                smp[0]    = tx;
            end
        end else begin
            rx_k++;
            smp[rx_k] = tx;
            if (rx_k == 10*CPB-1) begin
                ok = 1'b1;
                d  = 8'h00;
                for (int b = 0; b < 10; b++)
                    for (int c = 1; c < CPB; c++)
                        if (smp[b*CPB+c] !== smp[b*CPB]) ok = 1'b0;
                if (smp[0] !== 1'b0) ok = 1'b0;
                if (smp[9*CPB] !== 1'b1) ok = 1'b0;
                for (int j = 0; j < 8; j++) d[j] = smp[(j+1)*CPB];
                rx_data.push_back(d);
                rx_start.push_back(cur_start);
                rx_ok.push_back(ok);
                rx_act = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i;
        i = 0;
        while (rx_data.size() < n && i < budget) begin
            step();
            i++;
        end
        chk("frame_wait", 32'(rx_data.size() >= n), 32'd1);
    endtask

    initial begin
        int c0;
        int bc;
        logic [7:0] exp_b;

        reset = 1'b1;
        load  = 1'b0;
        din   = 8'h00;
        step();
        step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();

        // Single byte 0x2A; A changes right after the capture edge.
        din  = 8'h2A;
        load = 1'b1;
        step();
        load = 1'b0;
        din  = 8'hFF;
        c0   = cyc;
        chk("single_empty", 32'(empty), 32'd0);
        chk("single_tx_idle", 32'(tx), 32'd1);
        chk("single_busy0", 32'(busy), 32'd0);
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy) bc++;
            else if (bc > 0) break;
        end
        chk("single_busy_len", 32'(bc), 32'd40);
        chk("single_end_empty", 32'(empty), 32'd1);
        chk("single_end_tx", 32'(tx), 32'd1);
        wait_frames(1, 10);
        chk("single_data", 32'(rx_data[0]), 32'h2A);
        chk("single_shape", 32'(rx_ok[0]), 32'd1);
        chk("single_latency", 32'(rx_start[0]), 32'(c0 + 1));

        // Burst of six into a 4-deep queue: 0x06 is dropped.
        for (int i = 0; i < 6; i++) begin
            din  = 8'(i + 1);
            load = 1'b1;
            step();
        end
        load = 1'b0;
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_full", 32'(full), 32'd1);
        wait_frames(6, 400);
        for (int k = 1; k <= 5; k++) begin
            exp_b = 8'(k);
            chk("burst_data", 32'(rx_data[k]), 32'(exp_b));
            chk("burst_shape", 32'(rx_ok[k]), 32'd1);
        end
        for (int k = 1; k < 5; k++)
            chk("burst_gap", 32'(rx_start[k+1] - rx_start[k]), 32'd40);
        chk("burst_total", 32'(rx_start[5] - rx_start[1] + 40), 32'd200);
        repeat (60) step();
        chk("burst_no_sixth", 32'(rx_data.size()), 32'd6);
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);

        // Reset in data bit 3 of 0x55 with two more bytes queued.
        din  = 8'h55;
        load = 1'b1;
        step();
        din  = 8'h11;
        step();
        din  = 8'h22;
        step();
        load = 1'b0;
        repeat (16) step();
        chk("mid_bit3", 32'(tx), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b0;
        repeat (60) step();
        chk("arst_no_frames", 32'(rx_data.size()), 32'd6);
        chk("arst_tx_idle", 32'(tx), 32'd1);

        // Single OUT of 200, as from LDA 200; OUT.
        din  = 8'd200;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_frames(7, 100);
        chk("cpu_data", 32'(rx_data[6]), 32'hC8);
        chk("cpu_shape", 32'(rx_ok[6]), 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            step();
        end

        // Fill the queue, then push 0x77 exactly on the final stop cycle.
        for (int i = 0; i < 5; i++) begin
            din  = 8'hA1 + 8'(i);
            load = 1'b1;
            step();
        end
        load = 1'b0;
        chk("pop_edge_full", 32'(full), 32'd1);
        repeat (36) step();
        chk("pop_edge_stop", 32'(tx), 32'd1);
        din  = 8'h77;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("pop_edge_ovf", 32'(overflow), 32'd0);
        chk("pop_edge_full2", 32'(full), 32'd1);
        wait_frames(13, 400);
        for (int k = 0; k < 5; k++) begin
            exp_b = 8'hA1 + 8'(k);
            chk("pop_edge_data", 32'(rx_data[7+k]), 32'(exp_b));
        end
        chk("pop_edge_last", 32'(rx_data[12]), 32'h77);
        chk("pop_edge_shape", 32'(rx_ok[12]), 32'd1);
        chk("pop_edge_gap", 32'(rx_start[12] - rx_start[11]), 32'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_out.md
# uart_out

Output-port serializer for the 8-bit computer. It captures the A-register value whenever the control unit issues the OUT strobe and buffers it in a small FIFO. It then transmits each byte as an 8N1 asynchronous serial frame on a single `tx` line. It sits directly downstream of the CPU's OUT path and replaces the simulation-only `$display` output with a synthesizable, observable port.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be ≥ 2.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.
- `clk` in 1: system clock; all state changes on its rising edge (same edge as the A register).
- `reset` in 1: reset is asynchronous and active-high; clears all state immediately.
- `in` in 8: data to capture (A-register output).
- `load` in 1: OUT strobe; sampled each rising edge; one push per high cycle.
- `tx` out 1: serial line; idle high; LSB first.
- `busy` out 1: high whenever the transmitter state is not IDLE.
- `full` out 1: FIFO count == DEPTH.
- `empty` out 1: FIFO count == 0.
- `overflow` out 1: sticky; set when a push is dropped; cleared only by reset.

## Operation
- FIFO:
  - Push when `load` is high and (count < DEPTH, or a pop happens on the same edge).
  - Push while full with no pop: data dropped, `overflow` ← 1, FIFO unchanged.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Read and write pointers are log2(DEPTH) bits, wrap naturally. Count is log2(DEPTH)+1 bits.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `!empty`, pop head into shift register, go to START, bit counter ← 0, baud counter ← 0.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0]. Every CLKS_PER_BIT cycles: shift right, bit counter +1. After the 8th bit, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle: if `!empty`, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on the wrap.
- `tx` is driven from a register; it is never combinational from FSM inputs.
- `in` is captured only at the push edge. Later changes to A do not affect the queued data.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0. FSM=IDLE, pointers and counters = 0.
- Latency, idle block: `load` sampled at edge N → `empty`=0 after N → pop at edge N+1, `tx` falls after N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- `full`, `empty`, `busy` update on the same edge as the push or pop that changes them.
- Reset mid-frame: `tx` returns to 1 asynchronously, the partial frame is abandoned, and the FIFO contents are discarded. After deassertion the block behaves as from power-up.
- `load` held high for k cycles produces k push attempts. The CPU's OUT state lasts one cycle, giving one push.

## Structure
- Shared `parameters.v` additions:
  - `` `UART_IDLE ``=0, `` `UART_START ``=1, `` `UART_DATA ``=2, `` `UART_STOP ``=3 (2-bit state encoding).
  - Default CLKS_PER_BIT.
- Sub-module `fifo` (parameters N=8 width and DEPTH; ports `clk`, `reset`, `push`, `pop`, `in`, `out`, `full`, `empty`):
  - Synchronous, show-ahead head output.
  - Reusable for a future input port.
- `uart_out` holds the FSM, baud counter, bit counter, shift register, and the `overflow` flag.
- CPU integration: `in`←`rega_out`, `load`←`c_oi`. `tx` is monitored by a bench-side receiver.

## Test plan
- Reset: assert `reset` mid-simulation → `tx`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0 immediately, without waiting for a clock edge.
- Single byte 0x2A, CLKS_PER_BIT=4: one-cycle `load` → `tx` shows 0 | 0,1,0,1,0,1,0,0 | 1, each bit 4 cycles. `busy` stays high for 40 cycles, then `empty`=1 and `busy`=0.
- Burst, DEPTH=4: `load` high 6 consecutive cycles with 0x01..0x06:
  - 0x06 dropped and `overflow`=1.
  - Frames 0x01..0x05 sent back-to-back with no idle cycles (200 cycles total).
- Push at pop edge: FIFO full, assert `load`=0x77 exactly on the final STOP cycle → push accepted, `overflow` stays 0, 0x77 is transmitted last.
- Reset mid-frame: reset during DATA bit 3 of 0x55 with 2 bytes queued → `tx`=1 at once, FIFO empty. No further frames until a new `load`, and that new frame is correct.
- CPU integration: program `LDA x; OUT; HLT` with x=200 → one frame carrying 0xC8 is observed on `tx` before halt completes.
